// File: rtl/pokey_audio.sv
// pokey_audio: POKEY-style multi-channel tone/noise generator with a strobe/ack
// register port, two polynomial noise sources and a registered level mixer.
module pokey_audio #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 28,
    parameter int MIXW     = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       adr_i,
    input  logic [7:0]       dat_i,
    output logic [7:0]       dat_o,
    input  logic             we_i,
    input  logic             stb_i,
    output logic             ack_o,
    output logic [4*NCH-1:0] chan_o,
    output logic [MIXW-1:0]  mix_o
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [7:0]      audf_q [NCH];
    logic [7:0]      audf_d [NCH];
    logic [7:0]      audc_q [NCH];
    logic [7:0]      audc_d [NCH];
    logic [7:0]      cnt_q  [NCH];
    logic [7:0]      cnt_d  [NCH];
    logic [3:0]      level  [NCH];
    logic [NCH-1:0]  ff_q, ff_d;
    logic [7:0]      audctl_q, audctl_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      div_q, div_d;
    logic [16:0]     poly17_q, poly17_d;
    logic [8:0]      poly9_q, poly9_d;
    logic [7:0]      dat_q, dat_d;
    logic            ack_q, ack_d;
    logic [MIXW-1:0] mix_q, mix_d;
    logic [7:0]      rd_data;
    logic            raw_tick, base_tick, noise_bit, wr_en, rd_en;

    assign wr_en = stb_i & we_i;
    assign rd_en = stb_i & ~we_i;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (adr_i == 4'(2 * k))     rd_data = audf_q[k];
            if (adr_i == 4'(2 * k + 1)) rd_data = audc_q[k];
        end
        if (adr_i == 4'd14) rd_data = audctl_q[1] ? poly9_q[7:0] : poly17_q[7:0];
        if (adr_i == 4'd15) rd_data = audctl_q;
    end

    always_comb begin
        raw_tick  = (pre_q == PRE_LAST);
        pre_d     = raw_tick ? '0 : pre_q + PW'(1);
        div_d     = raw_tick ? div_q + 2'd1 : div_q;
        // The divide-by-4 counter free-runs so AUDCTL[0] changes never re-phase it.
        base_tick = raw_tick && (!audctl_q[0] || (div_q == 2'd3));
        noise_bit = audctl_q[1] ? poly9_q[8] : poly17_q[16];
        poly17_d  = {poly17_q[15:0], poly17_q[16] ^ poly17_q[11]};
        poly9_d   = {poly9_q[7:0], poly9_q[8] ^ poly9_q[3]};
        audctl_d  = (wr_en && adr_i == 4'd15) ? dat_i : audctl_q;
        dat_d     = rd_en ? rd_data : dat_q;
        ack_d     = stb_i;
    end

    // Reloads read the pre-write AUDF, so a same-edge AUDF write lands next reload.
    always_comb begin
        ff_d = ff_q;
        for (int k = 0; k < NCH; k++) begin
            audf_d[k] = audf_q[k];
            audc_d[k] = audc_q[k];
            cnt_d[k]  = cnt_q[k];
            if (base_tick) begin
                if (cnt_q[k] == 8'd0) begin
                    cnt_d[k] = audf_q[k];
                    ff_d[k]  = audc_q[k][7] ? ~ff_q[k] : noise_bit;
                end else begin
                    cnt_d[k] = cnt_q[k] - 8'd1;
                end
            end
            if (wr_en && adr_i == 4'(2 * k))     audf_d[k] = dat_i;
            if (wr_en && adr_i == 4'(2 * k + 1)) audc_d[k] = dat_i;
        end
    end

    always_comb begin
        chan_o = '0;
        mix_d  = '0;
        for (int k = 0; k < NCH; k++) begin
            level[k]          = (audc_q[k][4] || ff_q[k]) ? audc_q[k][3:0] : 4'd0;
            chan_o[4*k +: 4]  = level[k];
            mix_d             = mix_d + MIXW'(level[k]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NCH; k++) begin
                audf_q[k] <= '0;
                audc_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            ff_q     <= '0;
            audctl_q <= '0;
            pre_q    <= '0;
            div_q    <= '0;
            poly17_q <= '1;
            poly9_q  <= '1;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            mix_q    <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                audf_q[k] <= audf_d[k];
                audc_q[k] <= audc_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            ff_q     <= ff_d;
            audctl_q <= audctl_d;
            pre_q    <= pre_d;
            div_q    <= div_d;
            poly17_q <= poly17_d;
            poly9_q  <= poly9_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            mix_q    <= mix_d;
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign mix_o = mix_q;
endmodule

// File: tb/tb_pokey_audio.sv
// Self-checking bench for pokey_audio: directed scenarios plus randomized
// register traffic compared against a behavioural model of the sound chip.
module tb_pokey_audio;
    localparam int NCH = 4;
    localparam int PRESCALE = 4;
    localparam int MIXW = 6;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [3:0]       adr_i = '0;
    logic [7:0]       dat_i = '0;
    logic             we_i = 1'b0;
    logic             stb_i = 1'b0;
    logic [7:0]       dat_o;
    logic             ack_o;
    logic [4*NCH-1:0] chan_o;
    logic [MIXW-1:0]  mix_o;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    pokey_audio #(.NCH(NCH), .PRESCALE(PRESCALE), .MIXW(MIXW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .chan_o(chan_o), .mix_o(mix_o)
    );

    // Behavioural model: time is counted in clocks since reset, ticks derived by modulo.
    int          m_cyc, m_raw, m_audctl, m_dat, m_mix;
    int          m_audf [NCH];
    int          m_audc [NCH];
    int          m_cnt  [NCH];
    bit          m_ff   [NCH];
    bit          m_ack;
    logic [16:0] m_p17;
    logic [8:0]  m_p9;

    function automatic int m_level(input int k);
        if ((m_audc[k] & 16) != 0 || m_ff[k]) return m_audc[k] % 16;
        return 0;
    endfunction

    function automatic int m_read(input int a);
        if (a < 2 * NCH) return (a % 2 == 0) ? m_audf[a / 2] : m_audc[a / 2];
        if (a == 14) return ((m_audctl & 2) != 0) ? int'(m_p9[7:0]) : int'(m_p17[7:0]);
        if (a == 15) return m_audctl;
        return 0;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin : model_step
        int sum, rd;
        bit noise, raw, base;
        if (rst_i) begin
            for (int k = 0; k < NCH; k++) begin
                m_audf[k] = 0; m_audc[k] = 0; m_cnt[k] = 0; m_ff[k] = 0;
            end
            m_cyc = 0; m_raw = 0; m_audctl = 0; m_dat = 0; m_mix = 0; m_ack = 0;
            m_p17 = '1; m_p9 = '1;
        end else begin
            sum = 0;
            for (int k = 0; k < NCH; k++) sum += m_level(k);
            noise = ((m_audctl & 2) != 0) ? m_p9[8] : m_p17[16];
            raw = (m_cyc % PRESCALE) == PRESCALE - 1;
            base = raw && (((m_audctl & 1) == 0) || (m_raw % 4 == 3));
            rd = m_read(int'(adr_i));
            for (int k = 0; k < NCH; k++) begin
                if (base) begin
                    if (m_cnt[k] == 0) begin
                        m_cnt[k] = m_audf[k];
                        m_ff[k] = ((m_audc[k] & 128) != 0) ? !m_ff[k] : noise;
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end
            if (stb_i && we_i) begin
                if (int'(adr_i) < 2 * NCH) begin
                    if (adr_i[0]) m_audc[adr_i / 2] = int'(dat_i);
                    else m_audf[adr_i / 2] = int'(dat_i);
                end else if (adr_i == 4'd15) begin
                    m_audctl = int'(dat_i);
                end
            end
            if (stb_i && !we_i) m_dat = rd;
            m_ack = stb_i;
            m_mix = sum;
            m_p17 = {m_p17[15:0], m_p17[16] ^ m_p17[11]};
            m_p9 = {m_p9[7:0], m_p9[8] ^ m_p9[3]};
            m_cyc++;
            if (raw) m_raw++;
        end
    end

    task automatic apply_reset();
        stb_i = 0; we_i = 0; rst_i = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic do_write(input int a, input int d);
        adr_i = 4'(a); dat_i = 8'(d); we_i = 1; stb_i = 1;
        @(negedge clk_i);
        stb_i = 0; we_i = 0;
    endtask

    task automatic do_read(input int a);
        adr_i = 4'(a); we_i = 0; stb_i = 1;
        @(negedge clk_i);
        stb_i = 0;
    endtask

    task automatic wait_mix(input int val, input int limit, output bit ok);
        int n;
        n = 0;
        while (int'(mix_o) != val && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        ok = (int'(mix_o) == val);
    endtask

    task automatic run_len(input int val, input int limit, output int len);
        len = 0;
        while (int'(mix_o) == val && len < limit) begin
            len++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1;
        #1;
        total++; if (chan_o !== '0) begin bad++; $display("[TB] FAIL reset_chan: got %h want 0", chan_o); end
        total++; if (mix_o !== '0) begin bad++; $display("[TB] FAIL reset_mix: got %0d want 0", mix_o); end
        total++; if (ack_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", ack_o); end
        total++; if (dat_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_dat: got %h want 00", dat_o); end
        @(negedge clk_i);
        rst_i = 0;
        do_read(14);
        total++; if (dat_o !== 8'hFF) begin bad++; $display("[TB] FAIL reset_poly: got %h want ff", dat_o); end
        total++; if (ack_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_first_ack: got %b want 1", ack_o); end
        @(negedge clk_i);
        total++; if (ack_o !== 1'b0) begin bad++; $display("[TB] FAIL ack_drop: got %b want 0", ack_o); end
    endtask

    task automatic test_tone();
        bit ok;
        int len;
        apply_reset();
        do_write(0, 3);
        do_write(1, 8'hA5);
        wait_mix(5, 200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL tone_start: got mix %0d want 5", mix_o); end
        run_len(5, 200, len);
        total++; if (len != 16) begin bad++; $display("[TB] FAIL tone_high: got %0d want 16", len); end
        total++; if (mix_o !== 6'd0) begin bad++; $display("[TB] FAIL tone_low_val: got %0d want 0", mix_o); end
        run_len(0, 200, len);
        total++; if (len != 16) begin bad++; $display("[TB] FAIL tone_low: got %0d want 16", len); end
    endtask

    task automatic test_audctl();
        bit ok;
        int len;
        do_write(15, 8'h01);
        wait_mix(5, 1000, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL div4_start: got mix %0d want 5", mix_o); end
        wait_mix(0, 1000, ok);
        wait_mix(5, 1000, ok);
        run_len(5, 1000, len);
        total++; if (len != 64) begin bad++; $display("[TB] FAIL div4_high: got %0d want 64", len); end
        run_len(0, 1000, len);
        total++; if (len != 64) begin bad++; $display("[TB] FAIL div4_low: got %0d want 64", len); end
        len = 0;
        while (mix_o == 6'd5 && len < 1000) begin
            if (len == 10) begin adr_i = 0; dat_i = 8'd7; we_i = 1; stb_i = 1; end
            else begin stb_i = 0; we_i = 0; end
            len++;
            @(negedge clk_i);
        end
        stb_i = 0; we_i = 0;
        total++; if (len != 64) begin bad++; $display("[TB] FAIL audf_midcount: got %0d want 64", len); end
        run_len(0, 1000, len);
        total++; if (len != 128) begin bad++; $display("[TB] FAIL audf_reloaded_low: got %0d want 128", len); end
        run_len(5, 1000, len);
        total++; if (len != 128) begin bad++; $display("[TB] FAIL audf_reloaded_high: got %0d want 128", len); end
    endtask

    task automatic test_volume();
        apply_reset();
        do_write(1, 8'h1F);
        do_write(3, 8'h1F);
        total++; if (chan_o[7:0] !== 8'hFF) begin bad++; $display("[TB] FAIL vol_chan: got %h want ff", chan_o[7:0]); end
        total++; if (chan_o[15:8] !== 8'h00) begin bad++; $display("[TB] FAIL vol_idle_chan: got %h want 00", chan_o[15:8]); end
        @(negedge clk_i);
        total++; if (mix_o !== 6'd30) begin bad++; $display("[TB] FAIL vol_mix: got %0d want 30", mix_o); end
    endtask

    task automatic test_readback();
        int wv [16];
        int exp, r1;
        apply_reset();
        for (int a = 0; a < 16; a++) begin
            wv[a] = $urandom_range(0, 255);
            if (a == 15) wv[a] = wv[a] & 8'hFC;
            do_write(a, wv[a]);
        end
        for (int a = 0; a < 16; a++) begin
            exp = (a < 8 || a == 15) ? wv[a] : 0;
            if (a == 14) exp = m_read(14);
            do_read(a);
            total++; if (int'(dat_o) != exp) begin bad++; $display("[TB] FAIL read_%0d: got %h want %h", a, dat_o, exp); end
            total++; if (ack_o !== 1'b1) begin bad++; $display("[TB] FAIL read_ack_%0d: got %b want 1", a, ack_o); end
        end
        adr_i = 0; we_i = 0; stb_i = 1;
        for (int a = 0; a < 3; a++) begin
            adr_i = 4'(a);
            @(negedge clk_i);
            total++; if (ack_o !== 1'b1 || int'(dat_o) != wv[a]) begin
                bad++; $display("[TB] FAIL b2b_%0d: got ack %b dat %h want ack 1 dat %h", a, ack_o, dat_o, wv[a]);
            end
        end
        stb_i = 0;
        do_read(14);
        r1 = int'(dat_o);
        repeat (4) @(negedge clk_i);
        do_read(14);
        total++; if (int'(dat_o) == r1) begin bad++; $display("[TB] FAIL random_differ: got %h twice want different", dat_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        do_write(0, 1);
        do_write(1, 8'hAF);
        wait_mix(15, 200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL midrst_tone: got mix %0d want 15", mix_o); end
        adr_i = 1; we_i = 0; stb_i = 1;
        @(posedge clk_i);
        #2;
        total++; if (ack_o !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ack_before: got %b want 1", ack_o); end
        rst_i = 1;
        #1;
        total++; if (ack_o !== 1'b0 || chan_o !== '0 || mix_o !== '0) begin
            bad++; $display("[TB] FAIL midrst_clear: got ack %b chan %h mix %0d want 0", ack_o, chan_o, mix_o);
        end
        stb_i = 0;
        @(negedge clk_i);
        rst_i = 0;
        do_read(1);
        total++; if (dat_o !== 8'h00 || ack_o !== 1'b1) begin
            bad++; $display("[TB] FAIL midrst_read: got dat %h ack %b want 00 ack 1", dat_o, ack_o);
        end
    endtask

    task automatic test_random();
        logic [4*NCH-1:0] exp_chan;
        int op;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NCH; k++) exp_chan[4*k +: 4] = 4'(m_level(k));
            total++; if (chan_o !== exp_chan) begin bad++; $display("[TB] FAIL rnd_chan@%0d: got %h want %h", i, chan_o, exp_chan); end
            total++; if (mix_o !== MIXW'(m_mix)) begin bad++; $display("[TB] FAIL rnd_mix@%0d: got %0d want %0d", i, mix_o, m_mix); end
            total++; if (ack_o !== m_ack) begin bad++; $display("[TB] FAIL rnd_ack@%0d: got %b want %b", i, ack_o, m_ack); end
            total++; if (dat_o !== 8'(m_dat)) begin bad++; $display("[TB] FAIL rnd_dat@%0d: got %h want %h", i, dat_o, m_dat); end
            op = $urandom_range(0, 9);
            stb_i = 0; we_i = 0;
            adr_i = 4'($urandom_range(0, 15));
            dat_i = 8'($urandom);
            if (op < 3) begin
                stb_i = 1; we_i = 1;
                if (adr_i < 4'd8 && !adr_i[0]) dat_i = 8'($urandom_range(0, 5));
            end else if (op < 6) begin
                stb_i = 1;
            end
            @(negedge clk_i);
        end
        stb_i = 0; we_i = 0;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_tone();
        test_audctl();
        test_volume();
        test_readback();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pokey_audio.md
POKEY_AUDIO -- requirements
Module: pokey_audio

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of audio channels (legal range 1..7).
REQ-002 SHALL have parameter PRESCALE, default 28, meaning clk_i cycles per base tick (legal range >=2).
REQ-003 SHALL have parameter MIXW, default 6, meaning the mix output width (SHALL be >= 4+ceil(log2(NCH))).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port adr_i, input, 4 bits: register address.
REQ-007 SHALL have port dat_i, input, 8 bits: write data.
REQ-008 SHALL have port dat_o, output, 8 bits: registered read data.
REQ-009 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read, qualified by stb_i.
REQ-010 SHALL have port stb_i, input, 1 bit: access strobe.
REQ-011 SHALL have port ack_o, output, 1 bit: access acknowledge.
REQ-012 SHALL have port chan_o, output, 4*NCH bits: per-channel level, channel k at bits [4k+3:4k].
REQ-013 SHALL have port mix_o, output, MIXW bits: registered unsigned sum of all channel levels.

Function
REQ-014 Register map SHALL be: 2k = AUDF[k], 2k+1 = AUDC[k] for k<NCH; 14 = RANDOM (read-only); 15 = AUDCTL; all other addresses read 0 and ignore writes.
REQ-015 Write SHALL take effect at the edge where stb_i=1 and we_i=1; RANDOM writes are ignored.
REQ-016 Read SHALL load dat_o at the edge where stb_i=1 and we_i=0; dat_o SHALL otherwise hold its value.
REQ-017 ack_o SHALL be 1 for exactly the cycle after each strobed cycle; a continuously held stb_i SHALL be acked every cycle.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 and wrap; it SHALL raise a raw tick on the cycle the count equals PRESCALE-1.
REQ-019 Base tick SHALL equal raw tick when AUDCTL[0]=0, and SHALL be every 4th raw tick when AUDCTL[0]=1 (divide-by-4 counter, reset to 0).
REQ-020 poly17 LFSR SHALL shift left every clock, new bit0 = bit16 XOR bit11; poly9 SHALL shift left every clock, new bit0 = bit8 XOR bit3.
REQ-021 The noise bit SHALL be poly17[16] when AUDCTL[1]=0 and poly9[8] when AUDCTL[1]=1; RANDOM SHALL read poly17[7:0] (or poly9[7:0] when AUDCTL[1]=1).
REQ-022 Each channel SHALL hold an 8-bit down-counter; on a base tick, a counter at 0 SHALL reload AUDF[k] and fire an event, otherwise it SHALL decrement; event period = (AUDF[k]+1) base ticks.
REQ-023 On an event, flip-flop ff[k] SHALL toggle if AUDC[k][7]=1 (pure tone), else SHALL load the noise bit.
REQ-024 A channel level SHALL be AUDC[k][3:0] if AUDC[k][4]=1 (volume-only), else ff[k] ? AUDC[k][3:0] : 0; chan_o SHALL be combinational from these registers.
REQ-025 mix_o SHALL be registered: the sum of levels one cycle after they change; no saturation.
REQ-026 An AUDF write SHALL NOT alter the running count; it SHALL apply at the next reload; a write on the same edge as a reload SHALL reload the old value.
REQ-027 An AUDC write SHALL affect chan_o in the next cycle and SHALL NOT reset the counter or ff.
REQ-028 An AUDCTL write SHALL NOT reset the prescaler or the divide-by-4 counter.

Reset
REQ-029 While rst_i=1, all AUDF/AUDC/AUDCTL, counters, ff, prescaler, dat_o, ack_o and mix_o SHALL be 0, and poly17/poly9 SHALL be all ones.
REQ-030 Reset asserted mid-access SHALL drop ack_o immediately; the first strobe after release SHALL be handled normally.

Verification (PRESCALE=4, NCH=4)
REQ-031 Write AUDF0=3, AUDC0=0xA5 -> mix_o toggles 0/5 with a 32-cycle period (16 cycles high, 16 low).
REQ-032 Same setup, then write AUDCTL=0x01 -> period becomes 128 cycles; AUDF0=7 written mid-count -> period changes only after the next reload.
REQ-033 Write AUDC0=0x1F, AUDC1=0x1F -> mix_o=30 two cycles after the second write; chan_o[7:0]=0xFF.
REQ-034 Read addresses 0..15 after writes -> written values returned with ack one cycle later; 8..13 read 0; two RANDOM reads 5 cycles apart differ.
REQ-035 Pulse rst_i during tone output -> chan_o=0, mix_o=0, ack_o=0 immediately; a read of AUDC0 afterwards returns 0x00.
